// File: rtl/fusion_pkg.sv
// rtl/fusion_pkg.sv - shared types, widths and bitbrick mapping tables for fusion_mac
package fusion_pkg;

  typedef enum logic [1:0] {
    MODE_8X8  = 2'd0,
    MODE_4X4  = 2'd1,
    MODE_2X2  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int DOT_W  = 17;
  localparam int NBRICK = 16;

  // Left-shift applied to each brick product, 4 bits per brick, brick 0 in the low nibble.
  // 8x8: brick b pairs a-digit b%4 with w-digit b/4, shift 2*(i+j).
  localparam logic [63:0] SHIFT_8X8 = 64'hCA86_A864_8642_6420;
  // 4x4: four bricks per lane, (i,j) = (b%2, (b/2)%2), shift 2*(i+j).
  localparam logic [63:0] SHIFT_4X4 = 64'h4220_4220_4220_4220;
  // 2x2: one brick per lane, no shift.
  localparam logic [63:0] SHIFT_2X2 = 64'h0000_0000_0000_0000;

  typedef struct packed {
    logic        valid;
    logic        first;
    logic        last;
    mode_e       mode;
    logic        sign_a;
    logic        sign_w;
    logic [31:0] a;
    logic [31:0] w;
  } s1_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } ctrl_t;

  function automatic logic [3:0] brick_shift(input mode_e m, input int b);
    case (m)
      MODE_8X8: return SHIFT_8X8[4*b +: 4];
      MODE_4X4: return SHIFT_4X4[4*b +: 4];
      default:  return SHIFT_2X2[4*b +: 4];
    endcase
  endfunction

  // Bit position of the a-side digit feeding brick b. Bricks never straddle lanes,
  // so cross-lane products in the narrow modes are never formed.
  function automatic logic [4:0] a_digit_pos(input mode_e m, input int b);
    case (m)
      MODE_8X8: return 5'(2 * (b % 4));
      MODE_4X4: return 5'(4 * (b / 4) + 2 * (b % 2));
      default:  return 5'(2 * b);
    endcase
  endfunction

  function automatic logic [4:0] w_digit_pos(input mode_e m, input int b);
    case (m)
      MODE_8X8: return 5'(2 * (b / 4));
      MODE_4X4: return 5'(4 * (b / 4) + 2 * ((b / 2) % 2));
      default:  return 5'(2 * b);
    endcase
  endfunction

  // True when the a-side digit of brick b is the most significant digit of its lane.
  function automatic logic a_is_top(input mode_e m, input int b);
    case (m)
      MODE_8X8: return (b % 4) == 3;
      MODE_4X4: return (b % 2) == 1;
      default:  return 1'b1;
    endcase
  endfunction

  function automatic logic w_is_top(input mode_e m, input int b);
    case (m)
      MODE_8X8: return (b / 4) == 3;
      MODE_4X4: return ((b / 2) % 2) == 1;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fusion_mac_bitbrick.sv
// rtl/fusion_mac_bitbrick.sv - 3-bit signed by 3-bit signed bitbrick multiplier
module bitbrick (
  input  logic signed [2:0] a,
  input  logic signed [2:0] w,
  output logic signed [5:0] p
);

  assign p = a * w;

endmodule

// File: rtl/fusion_mac.sv
// rtl/fusion_mac.sv - bit-fusion MAC: 8x8 / 4-lane 4x4 / 16-lane 2x2 dot product with group accumulator
module fusion_mac
  import fusion_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic             sign_a,
  input  logic             sign_w,
  input  logic [31:0]      a,
  input  logic [31:0]      w,
  input  logic             acc_first,
  input  logic             acc_last,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             mode_err
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // group tracking at the input
  logic  grp_open_d, grp_open_q;
  mode_e grp_mode_d, grp_mode_q;
  logic  mode_err_d, mode_err_q;

  // pipeline
  s1_t   s1_d, s1_q;
  ctrl_t s2_ctrl_d, s2_ctrl_q;
  logic signed [DOT_W-1:0] s2_prod_d [NBRICK];
  logic signed [DOT_W-1:0] s2_prod_q [NBRICK];
  ctrl_t s3_ctrl_d, s3_ctrl_q;
  logic signed [DOT_W-1:0] s3_dot_d, s3_dot_q;

  // accumulator and output
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic        [ACC_W-1:0] acc_out_d, acc_out_q;
  logic                    out_valid_d, out_valid_q;

  // bitbrick operands and products
  logic signed [2:0] bb_a [NBRICK];
  logic signed [2:0] bb_w [NBRICK];
  logic signed [5:0] bb_p [NBRICK];

  // Admit or drop the incoming beat, tracking the open group and its mode
  always_comb begin
    grp_open_d  = grp_open_q;
    grp_mode_d  = grp_mode_q;
    mode_err_d  = mode_err_q;
    s1_d.valid  = 1'b0;
    s1_d.first  = acc_first;
    s1_d.last   = acc_last;
    s1_d.mode   = mode_e'(mode);
    s1_d.sign_a = sign_a;
    s1_d.sign_w = sign_w;
    s1_d.a      = a;
    s1_d.w      = w;
    if (in_valid) begin
      if (mode == MODE_RSVD) begin
        mode_err_d = 1'b1;
      end else if (acc_first || !grp_open_q) begin
        // a beat with no open group starts one, so it loads onto zero
        s1_d.valid = 1'b1;
        s1_d.first = 1'b1;
        grp_mode_d = mode_e'(mode);
        grp_open_d = !acc_last;
      end else if (mode != grp_mode_q) begin
        mode_err_d = 1'b1;
      end else begin
        s1_d.valid = 1'b1;
        if (acc_last) grp_open_d = 1'b0;
      end
    end
  end

  // Pick each brick's digit pair for the active mode; only a lane's top digit may be signed
  always_comb begin
    logic [1:0] a_pair;
    logic [1:0] w_pair;
    a_pair = 2'b00;
    w_pair = 2'b00;
    for (int b = 0; b < NBRICK; b++) begin
      a_pair  = s1_q.a[a_digit_pos(s1_q.mode, b) +: 2];
      w_pair  = s1_q.w[w_digit_pos(s1_q.mode, b) +: 2];
      bb_a[b] = {s1_q.sign_a & a_is_top(s1_q.mode, b) & a_pair[1], a_pair};
      bb_w[b] = {s1_q.sign_w & w_is_top(s1_q.mode, b) & w_pair[1], w_pair};
    end
  end

  for (genvar g = 0; g < NBRICK; g++) begin : g_brick
    bitbrick u_bitbrick (
      .a (bb_a[g]),
      .w (bb_w[g]),
      .p (bb_p[g])
    );
  end

  // Align each brick product to its digit weight and forward control
  always_comb begin
    for (int b = 0; b < NBRICK; b++) begin
      s2_prod_d[b] = DOT_W'(bb_p[b]) <<< brick_shift(s1_q.mode, b);
    end
    s2_ctrl_d.valid = s1_q.valid;
    s2_ctrl_d.first = s1_q.first;
    s2_ctrl_d.last  = s1_q.last;
  end

  // Reduce the aligned products into the fused dot sum
  always_comb begin
    s3_dot_d = '0;
    for (int b = 0; b < NBRICK; b++) begin
      s3_dot_d = s3_dot_d + s2_prod_q[b];
    end
    s3_ctrl_d = s2_ctrl_q;
  end

  // Load or add into the accumulator with optional saturation, emit on group end
  always_comb begin
    logic signed [ACC_W-1:0] dot_ext;
    logic signed [ACC_W:0]   acc_sum;
    dot_ext     = ACC_W'(s3_dot_q);
    acc_sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(dot_ext);
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    out_valid_d = 1'b0;
    if (s3_ctrl_q.valid) begin
      if (s3_ctrl_q.first) begin
        acc_d = dot_ext;
      end else if (SAT && (acc_sum[ACC_W] != acc_sum[ACC_W-1])) begin
        acc_d = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
      if (s3_ctrl_q.last) begin
        out_valid_d = 1'b1;
        acc_out_d   = acc_d;
      end
    end
  end

  // State registers; reset discards any group in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_open_q  <= 1'b0;
      grp_mode_q  <= MODE_8X8;
      mode_err_q  <= 1'b0;
      s1_q        <= '0;
      s2_ctrl_q   <= '0;
      s2_prod_q   <= '{default: '0};
      s3_ctrl_q   <= '0;
      s3_dot_q    <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      grp_open_q  <= grp_open_d;
      grp_mode_q  <= grp_mode_d;
      mode_err_q  <= mode_err_d;
      s1_q        <= s1_d;
      s2_ctrl_q   <= s2_ctrl_d;
      s2_prod_q   <= s2_prod_d;
      s3_ctrl_q   <= s3_ctrl_d;
      s3_dot_q    <= s3_dot_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_fusion_mac.sv
// tb/tb_fusion_mac.sv - bench for fusion_mac: directed literals plus random stimulus against a model
module tb_fusion_mac;

  localparam int NSLOT = 4096;
  localparam int NCFG  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  mode;
  logic        sign_a, sign_w;
  logic [31:0] a, w;
  logic        acc_first, acc_last;

  logic        ov_32, ov_s, ov_w;
  logic [31:0] acc_32;
  logic [16:0] acc_s, acc_w;
  logic        err_32, err_s, err_w;

  fusion_mac #(.ACC_W(32), .SAT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .sign_a(sign_a), .sign_w(sign_w),
    .a(a), .w(w), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov_32), .acc_out(acc_32), .mode_err(err_32));

  fusion_mac #(.ACC_W(17), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .sign_a(sign_a), .sign_w(sign_w),
    .a(a), .w(w), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov_s), .acc_out(acc_s), .mode_err(err_s));

  fusion_mac #(.ACC_W(17), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .sign_a(sign_a), .sign_w(sign_w),
    .a(a), .w(w), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(ov_w), .acc_out(acc_w), .mode_err(err_w));

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit done  = 1'b0;

  int cfg_w   [NCFG] = '{32, 17, 17};
  bit cfg_sat [NCFG] = '{1'b1, 1'b1, 1'b0};

  bit     ev_v   [NSLOT];
  longint ev_x   [NCFG][NSLOT];
  bit     rst_at [NSLOT];
  bit     err_at [NSLOT];

  longint m_acc [NCFG];
  bit     m_open;
  int     m_gmode;
  bit     m_err;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic longint lane_val(input logic [31:0] x, input int lo, input int width, input bit sgn);
    longint v;
    v = longint'(x >> lo) & ((longint'(1) << width) - 1);
    if (sgn && v[width-1]) v = v - (longint'(1) << width);
    return v;
  endfunction

  function automatic longint dot_of(input int md, input bit sa, input bit sw,
                                    input logic [31:0] av, input logic [31:0] wv);
    longint s;
    s = 0;
    case (md)
      0: s = lane_val(av, 0, 8, sa) * lane_val(wv, 0, 8, sw);
      1: for (int i = 0; i < 4; i++) s += lane_val(av, 4*i, 4, sa) * lane_val(wv, 4*i, 4, sw);
      default: for (int i = 0; i < 16; i++) s += lane_val(av, 2*i, 2, sa) * lane_val(wv, 2*i, 2, sw);
    endcase
    return s;
  endfunction

  function automatic longint fit(input longint v, input int wb, input bit sat);
    longint m, hi, lo, r;
    m  = longint'(1) << wb;
    hi = (m >> 1) - 1;
    lo = -(m >> 1);
    if (sat) begin
      r = (v > hi) ? hi : (v < lo) ? lo : v;
    end else begin
      r = v % m;
      if (r < 0) r += m;
      if (r > hi) r -= m;
    end
    return r;
  endfunction

  // model update for the edge just taken, using the inputs that were sampled there
  task automatic model_step();
    longint d;
    bit     take, first;
    cyc++;
    if (rst) begin
      rst_at[cyc] = 1'b1;
      for (int k = 0; k < NCFG; k++) m_acc[k] = 0;
      m_open = 1'b0;
      m_err  = 1'b0;
      for (int s = 0; s < 3; s++) ev_v[cyc+s] = 1'b0;
      err_at[cyc] = 1'b0;
      return;
    end
    take  = 1'b0;
    first = 1'b0;
    if (in_valid) begin
      if (mode == 2'd3) begin
        m_err = 1'b1;
      end else if (acc_first || !m_open) begin
        take = 1'b1; first = 1'b1;
        m_gmode = int'(mode);
        m_open  = !acc_last;
      end else if (int'(mode) != m_gmode) begin
        m_err = 1'b1;
      end else begin
        take = 1'b1;
        if (acc_last) m_open = 1'b0;
      end
    end
    if (take) begin
      d = dot_of(int'(mode), sign_a, sign_w, a, w);
      for (int k = 0; k < NCFG; k++)
        m_acc[k] = first ? fit(d, cfg_w[k], cfg_sat[k]) : fit(m_acc[k] + d, cfg_w[k], cfg_sat[k]);
      if (acc_last) begin
        ev_v[cyc+3] = 1'b1;
        for (int k = 0; k < NCFG; k++) ev_x[k][cyc+3] = m_acc[k];
      end
    end
    err_at[cyc] = m_err;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit iv, input logic [1:0] md, input bit sa, input bit sw,
                       input logic [31:0] av, input logic [31:0] wv, input bit f, input bit l);
    in_valid = iv; mode = md; sign_a = sa; sign_w = sw; a = av; w = wv; acc_first = f; acc_last = l;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // single-beat group; result must appear exactly three edges after the beat
  task automatic single(input string name, input logic [1:0] md, input bit sa, input bit sw,
                        input logic [31:0] av, input logic [31:0] wv, input longint exp);
    drive(1'b1, md, sa, sw, av, wv, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    tick();
    chk({name, "_early"}, longint'(ov_32), 0);
    tick();
    chk({name, "_valid"}, longint'(ov_32), 1);
    chk(name, longint'($signed(acc_32)), exp);
  endtask

  // every-cycle comparison of all three instances against the model
  initial begin
    longint hold [NCFG];
    for (int k = 0; k < NCFG; k++) hold[k] = 0;
    forever begin
      @(negedge clk);
      if (cyc > 0 && !done) begin
        if (rst_at[cyc]) begin
          for (int k = 0; k < NCFG; k++) hold[k] = 0;
        end else if (ev_v[cyc]) begin
          for (int k = 0; k < NCFG; k++) hold[k] = ev_x[k][cyc];
        end
        chk("ov_32",  longint'(ov_32), longint'(ev_v[cyc]));
        chk("ov_s",   longint'(ov_s),  longint'(ev_v[cyc]));
        chk("ov_w",   longint'(ov_w),  longint'(ev_v[cyc]));
        chk("acc_32", longint'($signed(acc_32)), hold[0]);
        chk("acc_s",  longint'($signed(acc_s)),  hold[1]);
        chk("acc_w",  longint'($signed(acc_w)),  hold[2]);
        chk("err_32", longint'(err_32), longint'(err_at[cyc]));
        chk("err_s",  longint'(err_s),  longint'(err_at[cyc]));
        chk("err_w",  longint'(err_w),  longint'(err_at[cyc]));
      end
    end
  end

  initial begin
    int gm;
    bit f, l;
    int r;
    logic [1:0] md;
    m_open = 1'b0; m_gmode = 0; m_err = 1'b0;
    for (int k = 0; k < NCFG; k++) m_acc[k] = 0;
    rst = 1'b1;
    idle();
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ov",  longint'(ov_32), 0);
    chk("reset_acc", longint'($signed(acc_32)), 0);
    chk("reset_err", longint'(err_32), 0);

    single("u8x8_ff",      2'd0, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_00FF, 65025);
    single("s8x8_neg",     2'd0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0002, -256);
    single("s8x8_ss",      2'd0, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0080, 16384);
    single("u4x4_dot",     2'd1, 1'b0, 1'b0, 32'hFFFF_4321, 32'hFFFF_1111, 10);
    single("s4x4_dot",     2'd1, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_1111, -4);
    single("s2x2_dot",     2'd2, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 64);
    single("u2x2_dot",     2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 144);

    // three-beat group: saturates at 17 bits, wraps at 17 bits, exact at 32 bits
    drive(1'b1, 2'd0, 1'b0, 1'b0, 32'hFF, 32'hFF, 1'b1, 1'b0); tick();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 32'hFF, 32'hFF, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd0, 1'b0, 1'b0, 32'hFF, 32'hFF, 1'b0, 1'b1); tick();
    idle(); tick(); tick(); tick();
    chk("acc3_valid", longint'(ov_s), 1);
    chk("acc3_sat17", longint'($signed(acc_s)), 65535);
    chk("acc3_wrap17", longint'($signed(acc_w)), 64003);
    chk("acc3_full32", longint'($signed(acc_32)), 195075);

    // mode mismatch drops a closing beat; the group closes on the next matching beat
    drive(1'b1, 2'd1, 1'b0, 1'b0, 32'h4321, 32'h1111, 1'b1, 1'b0); tick();
    drive(1'b1, 2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1); tick();
    chk("mismatch_err", longint'(err_32), 1);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 32'h0002, 32'h0003, 1'b0, 1'b1); tick();
    idle(); tick(); tick();
    chk("dropped_no_out", longint'(ov_32), 0);
    tick();
    chk("reopen_valid", longint'(ov_32), 1);
    chk("reopen_sum", longint'($signed(acc_32)), 16);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h1, 32'h1, 1'b1, 1'b1); tick();
    idle();
    chk("rsvd_err_sticky", longint'(err_32), 1);

    // reset in the middle of an open group
    drive(1'b1, 2'd0, 1'b0, 1'b0, 32'hFF, 32'hFF, 1'b1, 1'b0); tick();
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    chk("rst_err_clear", longint'(err_32), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_out", longint'(ov_32), 0);
    end
    single("after_rst", 2'd0, 1'b0, 1'b0, 32'h3, 32'h5, 15);

    // random phase
    gm = 0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 3) == 0);
      if (f) gm = $urandom_range(0, 2);
      r = $urandom_range(0, 19);
      if (r == 0) md = 2'd3;
      else if (r < 3) md = 2'($urandom_range(0, 2));
      else md = 2'(gm);
      drive(($urandom_range(0, 9) < 8), md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, f, l);
      tick();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 6; i++) tick();
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
